// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares the single Common Data Bus between the execution-side producers
// (index 0 = ALU, 1 = load/store buffer, 2 = branch unit). Each producer
// pushes {rob_tag, value} results into its own small FIFO. One FIFO head per
// cycle is granted round-robin and broadcast on the registered CDB outputs.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   rdy        global enable; low freezes every piece of state
//   flush      branch mispredict; drops every pending result
//   req_valid  per-producer result valid
//   req_ready  per-producer FIFO has room (combinational from the counts)
//   req_tag    packed ROB tags, producer i at [i*TAG_W +: TAG_W]
//   req_data   packed values, producer i at [i*DATA_W +: DATA_W]
//   cdb_valid  one-cycle broadcast pulse (registered)
//   cdb_tag    broadcast ROB tag (registered)
//   cdb_data   broadcast value (registered)
//   cdb_src    index of the producer that was granted (registered)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [TAG_W-1:0]  r_memTag  [NUM_REQ][BUF_DEPTH];
  logic [DATA_W-1:0] r_memData [NUM_REQ][BUF_DEPTH];
  logic [PTR_W-1:0]  r_rdPtr   [NUM_REQ];
  logic [PTR_W-1:0]  r_wrPtr   [NUM_REQ];
  logic [CNT_W-1:0]  r_count   [NUM_REQ];
  logic [SRC_W-1:0]  r_rrPtr;

  logic              r_cdbValid;
  logic [TAG_W-1:0]  r_cdbTag;
  logic [DATA_W-1:0] r_cdbData;
  logic [SRC_W-1:0]  r_cdbSrc;

  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;
  logic               w_grantValid;
  logic [SRC_W-1:0]   w_grantIdx;
  logic [SRC_W-1:0]   w_rrNext;
  logic [TAG_W-1:0]   w_headTag;
  logic [DATA_W-1:0]  w_headData;

  // (base + off) wrapped into 0..NUM_REQ-1; off never exceeds NUM_REQ-1, so a
  // single conditional subtract replaces a general modulo.
  function automatic logic [SRC_W-1:0] wrapIdx(input logic [SRC_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SRC_W'(s);
  endfunction

  // Ready depends only on the stored count: a full FIFO refuses a push even
  // when its head is being popped in the same cycle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (r_count[i] < CNT_W'(BUF_DEPTH));
    end
  end

  // Round-robin search. Scanning offsets from the far end down lets the
  // smallest offset from r_rrPtr overwrite any later candidate.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (r_count[wrapIdx(r_rrPtr, off)] != '0) begin
        w_grantValid = 1'b1;
        w_grantIdx   = wrapIdx(r_rrPtr, off);
      end
    end
  end

  // Head of the granted FIFO and the pointer value that follows the grant.
  always_comb begin
    w_headTag  = r_memTag[w_grantIdx][r_rdPtr[w_grantIdx]];
    w_headData = r_memData[w_grantIdx][r_rdPtr[w_grantIdx]];
    w_rrNext   = (w_grantIdx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + SRC_W'(1);
  end

  // Push/pop strobes. A flush or a stalled cycle suppresses both, so the
  // sequential blocks can use them without re-checking rdy/flush.
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_push[i] = req_valid[i] & req_ready[i] & rdy & ~flush;
      w_pop[i]  = rdy & ~flush & w_grantValid & (w_grantIdx == SRC_W'(i));
    end
  end

  // FIFO storage holds only datapath values; validity lives in r_count, so
  // the arrays need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_push[i]) begin
        r_memTag[i][r_wrPtr[i]]  <= req_tag[i*TAG_W +: TAG_W];
        r_memData[i][r_wrPtr[i]] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because BUF_DEPTH
  // is a power of two. Flush empties every FIFO and restarts arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rdPtr[i] <= '0;
        r_wrPtr[i] <= '0;
        r_count[i] <= '0;
      end
      r_rrPtr <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          r_rdPtr[i] <= '0;
          r_wrPtr[i] <= '0;
          r_count[i] <= '0;
        end
        r_rrPtr <= '0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (w_push[i]) r_wrPtr[i] <= r_wrPtr[i] + PTR_W'(1);
          if (w_pop[i])  r_rdPtr[i] <= r_rdPtr[i] + PTR_W'(1);
          case ({w_push[i], w_pop[i]})
            2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
            2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
            default: r_count[i] <= r_count[i];
          endcase
        end
        if (w_grantValid) r_rrPtr <= w_rrNext;
      end
    end
  end

  // Broadcast register. When nothing is granted only the valid bit drops;
  // tag, data and source keep the last broadcast values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cdbValid <= 1'b0;
      r_cdbTag   <= '0;
      r_cdbData  <= '0;
      r_cdbSrc   <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_cdbValid <= 1'b0;
      end else if (w_grantValid) begin
        r_cdbValid <= 1'b1;
        r_cdbTag   <= w_headTag;
        r_cdbData  <= w_headData;
        r_cdbSrc   <= w_grantIdx;
      end else begin
        r_cdbValid <= 1'b0;
      end
    end
  end

  assign cdb_valid = r_cdbValid;
  assign cdb_tag   = r_cdbTag;
  assign cdb_data  = r_cdbData;
  assign cdb_src   = r_cdbSrc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter: reset, round-robin order, back-pressure,
// flush, rdy stall and asynchronous reset in the middle of a stream.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [2:0]  reqValid;
  logic [2:0]  reqReady;
  logic [11:0] reqTag;
  logic [95:0] reqData;
  logic        cdbValid;
  logic [3:0]  cdbTag;
  logic [31:0] cdbData;
  logic [1:0]  cdbSrc;

  int nCompared   = 0;
  int nMismatched = 0;

  cdb_arbiter #(
    .NUM_REQ(3), .TAG_W(4), .DATA_W(32), .BUF_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_tag(reqTag), .req_data(reqData),
    .cdb_valid(cdbValid), .cdb_tag(cdbTag), .cdb_data(cdbData), .cdb_src(cdbSrc)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value carried with each tag, so data checks follow from the tag alone.
  function automatic logic [31:0] dataFor(input logic [3:0] tag);
    return 32'hD000_0000 | (32'(tag) * 32'h0001_0101);
  endfunction

  // Advance one rising edge and land 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a result on one producer port for the coming edge.
  task automatic applyStimulus(input int idx, input logic [3:0] tag);
    reqValid[idx]          = 1'b1;
    reqTag[idx*4 +: 4]     = tag;
    reqData[idx*32 +: 32]  = dataFor(tag);
  endtask

  task automatic clearStimulus();
    reqValid = 3'b000;
    reqTag   = '0;
    reqData  = '0;
  endtask

  // Reset held with random inputs, then the first single-result latency.
  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rdy      = 1'($urandom);
      flush    = 1'($urandom);
      reqValid = 3'($urandom);
      reqTag   = 12'($urandom);
      reqData  = {$urandom, $urandom, $urandom};
      tick();
      nCompared++;
      if (cdbValid !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL reset_valid[%0d]: got %b expected 0", k, cdbValid);
      end
      nCompared++;
      if (reqReady !== 3'b111) begin
        nMismatched++;
        $display("[TB] FAIL reset_ready[%0d]: got %b expected 111", k, reqReady);
      end
    end
    nCompared++;
    if (cdbTag !== 4'd0 || cdbData !== 32'd0 || cdbSrc !== 2'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_fields: got tag=%0d data=%h src=%0d expected 0/0/0",
               cdbTag, cdbData, cdbSrc);
    end
    clearStimulus();
    rdy   = 1'b1;
    flush = 1'b0;
    rst   = 1'b1;
    tick();
    reqValid[0] = 1'b1;
    reqTag[3:0] = 4'd5;
    reqData[31:0] = 32'h0000_1234;
    tick();
    clearStimulus();
    nCompared++;
    if (cdbValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL first_not_same_cycle: got valid=%b expected 0", cdbValid);
    end
    tick();
    nCompared++;
    if (cdbValid !== 1'b1 || cdbTag !== 4'd5 || cdbData !== 32'h0000_1234 || cdbSrc !== 2'd0) begin
      nMismatched++;
      $display("[TB] FAIL first_result: got v=%b tag=%0d data=%h src=%0d expected 1/5/00001234/0",
               cdbValid, cdbTag, cdbData, cdbSrc);
    end
    tick();
    nCompared++;
    if (cdbValid !== 1'b0 || cdbTag !== 4'd5) begin
      nMismatched++;
      $display("[TB] FAIL first_pulse_end: got v=%b tag=%0d expected 0/5", cdbValid, cdbTag);
    end
  endtask

  // Three simultaneous pushes drained in pointer order, from ptr=0 then ptr=1.
  task automatic test_round_robin();
    logic [3:0] expTagA [3];
    logic [1:0] expSrcA [3];
    logic [3:0] expTagB [3];
    logic [1:0] expSrcB [3];
    expTagA = '{4'd1, 4'd2, 4'd3};
    expSrcA = '{2'd0, 2'd1, 2'd2};
    expTagB = '{4'd2, 4'd3, 4'd1};
    expSrcB = '{2'd1, 2'd2, 2'd0};

    // After test_reset the pointer sits at 1 (last grant was ALU), so park it
    // at 0 with a single branch-unit result first.
    applyStimulus(2, 4'd9);
    tick();
    clearStimulus();
    tick();
    tick();

    applyStimulus(0, 4'd1);
    applyStimulus(1, 4'd2);
    applyStimulus(2, 4'd3);
    tick();
    clearStimulus();
    for (int k = 0; k < 3; k++) begin
      tick();
      nCompared++;
      if (cdbValid !== 1'b1 || cdbTag !== expTagA[k] || cdbSrc !== expSrcA[k] ||
          cdbData !== dataFor(expTagA[k])) begin
        nMismatched++;
        $display("[TB] FAIL rr_ptr0[%0d]: got v=%b tag=%0d src=%0d data=%h expected 1/%0d/%0d/%h",
                 k, cdbValid, cdbTag, cdbSrc, cdbData, expTagA[k], expSrcA[k], dataFor(expTagA[k]));
      end
    end
    tick();
    nCompared++;
    if (cdbValid !== 1'b0 || cdbTag !== 4'd3 || cdbSrc !== 2'd2) begin
      nMismatched++;
      $display("[TB] FAIL rr_idle_hold: got v=%b tag=%0d src=%0d expected 0/3/2",
               cdbValid, cdbTag, cdbSrc);
    end

    // One ALU grant moves the pointer to 1.
    applyStimulus(0, 4'd4);
    tick();
    clearStimulus();
    tick();
    tick();

    applyStimulus(0, 4'd1);
    applyStimulus(1, 4'd2);
    applyStimulus(2, 4'd3);
    tick();
    clearStimulus();
    for (int k = 0; k < 3; k++) begin
      tick();
      nCompared++;
      if (cdbValid !== 1'b1 || cdbTag !== expTagB[k] || cdbSrc !== expSrcB[k]) begin
        nMismatched++;
        $display("[TB] FAIL rr_ptr1[%0d]: got v=%b tag=%0d src=%0d expected 1/%0d/%0d",
                 k, cdbValid, cdbTag, cdbSrc, expTagB[k], expSrcB[k]);
      end
    end
    tick();
    nCompared++;
    if (cdbValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rr_ptr1_end: got v=%b expected 0", cdbValid);
    end
  endtask

  // LSB fills its FIFO while the ALU stays busy; a push into the full FIFO
  // must be refused and never broadcast.
  task automatic test_back_pressure();
    logic [3:0] expTag [3];
    logic [1:0] expSrc [3];
    expTag = '{4'd3, 4'd4, 4'd5};
    expSrc = '{2'd0, 2'd1, 2'd0};

    // Single-cycle flush parks the pointer at 0.
    flush = 1'b1;
    tick();
    flush = 1'b0;

    applyStimulus(0, 4'd1);
    applyStimulus(1, 4'd2);
    tick();
    nCompared++;
    if (reqReady !== 3'b111) begin
      nMismatched++;
      $display("[TB] FAIL bp_ready_one_each: got %b expected 111", reqReady);
    end
    applyStimulus(0, 4'd3);
    applyStimulus(1, 4'd4);
    tick();
    nCompared++;
    if (reqReady !== 3'b101 || cdbTag !== 4'd1 || cdbSrc !== 2'd0) begin
      nMismatched++;
      $display("[TB] FAIL bp_lsb_full: got ready=%b tag=%0d src=%0d expected 101/1/0",
               reqReady, cdbTag, cdbSrc);
    end
    applyStimulus(0, 4'd5);
    applyStimulus(1, 4'd6);
    tick();
    clearStimulus();
    nCompared++;
    if (reqReady !== 3'b110 || cdbValid !== 1'b1 || cdbTag !== 4'd2 || cdbSrc !== 2'd1) begin
      nMismatched++;
      $display("[TB] FAIL bp_lsb_granted: got ready=%b v=%b tag=%0d src=%0d expected 110/1/2/1",
               reqReady, cdbValid, cdbTag, cdbSrc);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      nCompared++;
      if (cdbValid !== 1'b1 || cdbTag !== expTag[k] || cdbSrc !== expSrc[k]) begin
        nMismatched++;
        $display("[TB] FAIL bp_drain[%0d]: got v=%b tag=%0d src=%0d expected 1/%0d/%0d",
                 k, cdbValid, cdbTag, cdbSrc, expTag[k], expSrc[k]);
      end
    end
    tick();
    nCompared++;
    if (cdbValid !== 1'b0 || reqReady !== 3'b111) begin
      nMismatched++;
      $display("[TB] FAIL bp_refused_push: got v=%b ready=%b expected 0/111", cdbValid, reqReady);
    end
  endtask

  // Four results pending, one flush cycle with pushes attempted alongside.
  task automatic test_flush();
    applyStimulus(0, 4'd8);
    applyStimulus(1, 4'd9);
    applyStimulus(2, 4'd10);
    tick();
    applyStimulus(0, 4'd11);
    applyStimulus(1, 4'd12);
    reqValid[2] = 1'b0;
    tick();
    nCompared++;
    if (cdbValid !== 1'b1 || cdbTag !== 4'd9 || cdbSrc !== 2'd1) begin
      nMismatched++;
      $display("[TB] FAIL flush_pre: got v=%b tag=%0d src=%0d expected 1/9/1", cdbValid, cdbTag, cdbSrc);
    end
    clearStimulus();
    applyStimulus(0, 4'd13);
    applyStimulus(2, 4'd14);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clearStimulus();
    nCompared++;
    if (cdbValid !== 1'b0 || reqReady !== 3'b111) begin
      nMismatched++;
      $display("[TB] FAIL flush_cycle: got v=%b ready=%b expected 0/111", cdbValid, reqReady);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      nCompared++;
      if (cdbValid !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL flush_stale[%0d]: got v=%b tag=%0d expected v=0", k, cdbValid, cdbTag);
      end
    end
  endtask

  // rdy low for three edges with tag 7 on the bus; nothing moves.
  task automatic test_rdy_stall();
    applyStimulus(0, 4'd7);
    applyStimulus(1, 4'd14);
    tick();
    clearStimulus();
    tick();
    nCompared++;
    if (cdbValid !== 1'b1 || cdbTag !== 4'd7 || cdbSrc !== 2'd0) begin
      nMismatched++;
      $display("[TB] FAIL stall_pre: got v=%b tag=%0d src=%0d expected 1/7/0", cdbValid, cdbTag, cdbSrc);
    end
    rdy = 1'b0;
    applyStimulus(2, 4'd15);
    for (int k = 0; k < 3; k++) begin
      tick();
      nCompared++;
      if (cdbValid !== 1'b1 || cdbTag !== 4'd7 || cdbSrc !== 2'd0 ||
          cdbData !== dataFor(4'd7) || reqReady !== 3'b111) begin
        nMismatched++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b tag=%0d src=%0d ready=%b expected 1/7/0/111",
                 k, cdbValid, cdbTag, cdbSrc, reqReady);
      end
    end
    clearStimulus();
    rdy = 1'b1;
    tick();
    nCompared++;
    if (cdbValid !== 1'b1 || cdbTag !== 4'd14 || cdbSrc !== 2'd1) begin
      nMismatched++;
      $display("[TB] FAIL stall_resume: got v=%b tag=%0d src=%0d expected 1/14/1", cdbValid, cdbTag, cdbSrc);
    end
    tick();
    nCompared++;
    if (cdbValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL stall_no_push: got v=%b tag=%0d expected v=0", cdbValid, cdbTag);
    end
  endtask

  // Reset dropped between edges while a result is on the bus and another waits.
  task automatic test_async_reset();
    applyStimulus(0, 4'd12);
    applyStimulus(1, 4'd13);
    tick();
    clearStimulus();
    tick();
    nCompared++;
    if (cdbValid !== 1'b1 || cdbTag !== 4'd12) begin
      nMismatched++;
      $display("[TB] FAIL areset_pre: got v=%b tag=%0d expected 1/12", cdbValid, cdbTag);
    end
    #3;
    rst = 1'b0;
    #1;
    nCompared++;
    if (cdbValid !== 1'b0 || cdbTag !== 4'd0 || reqReady !== 3'b111) begin
      nMismatched++;
      $display("[TB] FAIL areset_immediate: got v=%b tag=%0d ready=%b expected 0/0/111",
               cdbValid, cdbTag, reqReady);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      nCompared++;
      if (cdbValid !== 1'b0 || reqReady !== 3'b111) begin
        nMismatched++;
        $display("[TB] FAIL areset_empty[%0d]: got v=%b ready=%b expected 0/111", k, cdbValid, reqReady);
      end
    end
  endtask

  initial begin
    rdy   = 1'b1;
    flush = 1'b0;
    rst   = 1'b0;
    clearStimulus();
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_flush();
    test_rdy_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
